// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op bit positions,
// FSM state encoding and the default divider iteration count.
package md_pkg;

   localparam int MD_MULT  = 0;
   localparam int MD_MULTU = 1;
   localparam int MD_DIV   = 2;
   localparam int MD_DIVU  = 3;
   localparam int MD_MFHI  = 4;
   localparam int MD_MFLO  = 5;
   localparam int MD_MTHI  = 6;
   localparam int MD_MTLO  = 7;

   localparam int DIV_ITERS_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

endpackage

// File: rtl/div_iter.sv
// Unsigned 32/32 restoring divider, one quotient bit per clock. The quotient/remainder
// outputs are the result of the step in progress, so they are final while last is high.
module div_iter #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clear,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);
   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic [31:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [32:0]   shifted, diff;
   logic [31:0]   quo_step, rem_step;

   // A set bit 32 of diff means the trial subtraction went negative: restore.
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_q};
      if (diff[32]) begin
         rem_step = shifted[31:0];
         quo_step = {quo_q[30:0], 1'b0};
      end else begin
         rem_step = diff[31:0];
         quo_step = {quo_q[30:0], 1'b1};
      end
   end

   assign last      = run_q && (cnt_q == CW'(ITERS - 1));
   assign quotient  = quo_step;
   assign remainder = rem_step;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (clear) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         quo_d = dividend;
         rem_d = 32'd0;
         dvs_d = divisor;
      end else if (run_q) begin
         quo_d = quo_step;
         rem_d = rem_step;
         if (last) begin
            run_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
         quo_q <= 32'd0;
         rem_q <= 32'd0;
         dvs_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller for the EXE stage: single-cycle multiply, iterative
// divide, MFHI/MFLO reads, MTHI/MTLO writes and clean abort on flush.
//
// state | meaning
// IDLE  | nothing in flight; MF/MT ops are served here
// MUL   | operands latched, product committed on the next edge
// DIV   | divider iterating, HI/LO written on the final iteration
// DONE  | result committed, ready held high until EXE moves on
module muldiv_ctrl
   import md_pkg::*;
#(
   parameter int DIV_ITERS = DIV_ITERS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exe_valid_in,
   input  logic [7:0]  exe_op_in,
   input  logic [31:0] exe_src1_in,
   input  logic [31:0] exe_src2_in,
   input  logic        exe_go_in,
   input  logic        exe_cancel_in,
   output logic        md_ready_out,
   output logic        md_busy_out,
   output logic [31:0] md_rdata_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);
   md_state_e   state_q, state_d;
   logic        sgn_q, sgn_d;
   logic [31:0] src1_q, src1_d, src2_q, src2_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        start_ok, is_mul_op, div_start, div_last;
   logic [31:0] div_dividend, div_divisor, div_quo, div_rem;
   logic [31:0] quo_fix, rem_fix;
   logic [63:0] mul_a, mul_b, product;

   assign start_ok  = exe_valid_in && (exe_op_in[3:0] != 4'b0) && !exe_cancel_in;
   assign is_mul_op = exe_op_in[MD_MULT] | exe_op_in[MD_MULTU];

   // The divider loads magnitudes straight from the EXE operands on the start edge.
   assign div_dividend = (exe_op_in[MD_DIV] && exe_src1_in[31]) ? (32'd0 - exe_src1_in)
                                                                 : exe_src1_in;
   assign div_divisor  = (exe_op_in[MD_DIV] && exe_src2_in[31]) ? (32'd0 - exe_src2_in)
                                                                 : exe_src2_in;

   div_iter #(.ITERS(DIV_ITERS)) u_div_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .clear     (exe_cancel_in),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .quotient  (div_quo),
      .remainder (div_rem),
      .last      (div_last)
   );

   always_comb begin
      quo_fix = div_quo;
      rem_fix = div_rem;
      if (src2_q == 32'd0) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = src1_q;
      end else if (sgn_q) begin
         if (src1_q[31] ^ src2_q[31]) quo_fix = 32'd0 - div_quo;
         if (src1_q[31])              rem_fix = 32'd0 - div_rem;
      end
   end

   // Sign- or zero-extend to 64 bits so one multiplier covers MULT and MULTU.
   assign mul_a   = {{32{sgn_q & src1_q[31]}}, src1_q};
   assign mul_b   = {{32{sgn_q & src2_q[31]}}, src2_q};
   assign product = mul_a * mul_b;

   always_comb begin
      state_d   = state_q;
      sgn_d     = sgn_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div_start = 1'b0;

      if (exe_valid_in && exe_go_in && !exe_cancel_in) begin
         if (exe_op_in[MD_MTHI]) hi_d = exe_src1_in;
         if (exe_op_in[MD_MTLO]) lo_d = exe_src1_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               src1_d = exe_src1_in;
               src2_d = exe_src2_in;
               sgn_d  = exe_op_in[MD_MULT] | exe_op_in[MD_DIV];
               if (is_mul_op) begin
                  state_d = ST_MUL;
               end else begin
                  state_d   = ST_DIV;
                  div_start = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (exe_cancel_in) begin
               state_d = ST_IDLE;
            end else begin
               hi_d    = product[63:32];
               lo_d    = product[31:0];
               state_d = ST_DONE;
            end
         end
         ST_DIV: begin
            if (exe_cancel_in) begin
               state_d = ST_IDLE;
            end else if (div_last) begin
               hi_d    = rem_fix;
               lo_d    = quo_fix;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (exe_go_in || exe_cancel_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sgn_q   <= 1'b0;
         src1_q  <= 32'd0;
         src2_q  <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         sgn_q   <= sgn_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign md_ready_out = !exe_valid_in || (state_q == ST_DONE) ||
                         ((state_q == ST_IDLE) && (exe_op_in[3:0] == 4'b0));
   assign md_busy_out  = (state_q != ST_IDLE);
   assign hi_out       = hi_q;
   assign lo_out       = lo_q;

   always_comb begin
      md_rdata_out = 32'd0;
      if (exe_valid_in && exe_op_in[MD_MFHI])      md_rdata_out = hi_q;
      else if (exe_valid_in && exe_op_in[MD_MFLO]) md_rdata_out = lo_q;
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_ctrl;
   import md_pkg::*;

   localparam int DIV_ITERS = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exe_valid_in, exe_go_in, exe_cancel_in;
   logic [7:0]  exe_op_in;
   logic [31:0] exe_src1_in, exe_src2_in;
   logic        md_ready_out, md_busy_out;
   logic [31:0] md_rdata_out, hi_out, lo_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.DIV_ITERS(DIV_ITERS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .exe_valid_in  (exe_valid_in),
      .exe_op_in     (exe_op_in),
      .exe_src1_in   (exe_src1_in),
      .exe_src2_in   (exe_src2_in),
      .exe_go_in     (exe_go_in),
      .exe_cancel_in (exe_cancel_in),
      .md_ready_out  (md_ready_out),
      .md_busy_out   (md_busy_out),
      .md_rdata_out  (md_rdata_out),
      .hi_out        (hi_out),
      .lo_out        (lo_out)
   );

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      exe_valid_in  = 1'b0;
      exe_op_in     = 8'd0;
      exe_go_in     = 1'b0;
      exe_cancel_in = 1'b0;
      exe_src1_in   = 32'd0;
      exe_src2_in   = 32'd0;
   endtask

   // Returns {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] model(input int opb, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub;
      logic [63:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = 64'd0;
      case (opb)
         MD_MULT:  begin p = sa * sb; r = p; end
         MD_MULTU: r = ua * ub;
         MD_DIV:   r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
         MD_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default:  r = 64'd0;
      endcase
      return r;
   endfunction

   // Issue one mult/div at a negedge, count ready-low cycles, hold DONE, then retire.
   task automatic run_op(input int opb, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int estall,
                         input int hold, input string nm);
      int          stall;
      logic [31:0] hi0, lo0;
      logic        early;
      hi0   = hi_out;
      lo0   = lo_out;
      early = 1'b0;
      stall = 0;
      exe_valid_in  = 1'b1;
      exe_op_in     = 8'(1 << opb);
      exe_src1_in   = a;
      exe_src2_in   = b;
      exe_go_in     = 1'b0;
      exe_cancel_in = 1'b0;
      #1;
      while (!md_ready_out && stall < 100) begin
         if (hi_out !== hi0 || lo_out !== lo0) early = 1'b1;
         @(negedge clk);
         stall++;
      end
      check({nm, "_stall"}, 32'(stall), 32'(estall));
      check({nm, "_early_write"}, {31'd0, early}, 32'd0);
      check({nm, "_hi"}, hi_out, ehi);
      check({nm, "_lo"}, lo_out, elo);
      check({nm, "_busy_done"}, {31'd0, md_busy_out}, 32'd1);
      check({nm, "_rdata_nonmf"}, md_rdata_out, 32'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({nm, "_hold_ready"}, {31'd0, md_ready_out}, 32'd1);
         check({nm, "_hold_lo"}, lo_out, elo);
      end
      exe_go_in = 1'b1;
      @(negedge clk);
      check({nm, "_busy_after_go"}, {31'd0, md_busy_out}, 32'd0);
      check({nm, "_hi_after_go"}, hi_out, ehi);
      drive_idle();
   endtask

   // Issue an op, raise cancel in busy cycle at_cycle (1 = first cycle after the start edge).
   task automatic cancel_op(input int opb, input int at_cycle, input string nm);
      logic [31:0] hi0, lo0;
      hi0 = hi_out;
      lo0 = lo_out;
      exe_valid_in  = 1'b1;
      exe_op_in     = 8'(1 << opb);
      exe_src1_in   = 32'd1000;
      exe_src2_in   = 32'd3;
      exe_go_in     = 1'b0;
      exe_cancel_in = 1'b0;
      repeat (at_cycle) @(negedge clk);
      check({nm, "_busy_before"}, {31'd0, md_busy_out}, 32'd1);
      exe_cancel_in = 1'b1;
      @(negedge clk);
      check({nm, "_busy"}, {31'd0, md_busy_out}, 32'd0);
      check({nm, "_hi"}, hi_out, hi0);
      check({nm, "_lo"}, lo_out, lo0);
      drive_idle();
      @(negedge clk);
      check({nm, "_hi_later"}, hi_out, hi0);
   endtask

   initial begin
      logic [63:0] r;
      logic [31:0] a, b;
      int          opb;

      drive_idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      check("rst_busy", {31'd0, md_busy_out}, 32'd0);
      check("rst_rdata", md_rdata_out, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", {31'd0, md_ready_out}, 32'd1);

      vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
      vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
      vecs[2] = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
      vecs[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
      vecs[5] = '{MD_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 33};
      vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
      vecs[7] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};

      // Consecutive calls leave no idle cycle, so vecs[0..1] also cover back-to-back MULTs.
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].stall, 0,
                $sformatf("vec%0d", i));

      run_op(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 2, 3, "done_hold");

      cancel_op(MD_DIVU, 10, "cancel_div10");
      cancel_op(MD_DIVU, DIV_ITERS, "cancel_div_last");
      cancel_op(MD_MULT, 1, "cancel_mul");
      run_op(MD_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 0, "after_cancel");

      exe_valid_in = 1'b1;
      exe_op_in    = 8'(1 << MD_MTHI);
      exe_src1_in  = 32'h1234;
      exe_go_in    = 1'b1;
      #1;
      check("mthi_ready", {31'd0, md_ready_out}, 32'd1);
      @(negedge clk);
      exe_op_in   = 8'(1 << MD_MFHI);
      exe_src1_in = 32'd0;
      #1;
      check("mfhi_rdata", md_rdata_out, 32'h1234);
      exe_op_in   = 8'(1 << MD_MTLO);
      exe_src1_in = 32'hABCD;
      @(negedge clk);
      exe_op_in = 8'(1 << MD_MFLO);
      #1;
      check("mflo_rdata", md_rdata_out, 32'hABCD);
      check("mthi_hi_kept", hi_out, 32'h1234);
      exe_op_in     = 8'(1 << MD_MTHI);
      exe_src1_in   = 32'hDEAD;
      exe_cancel_in = 1'b1;
      @(negedge clk);
      check("mthi_cancel", hi_out, 32'h1234);
      exe_cancel_in = 1'b0;
      exe_go_in     = 1'b0;
      @(negedge clk);
      check("mthi_nogo", hi_out, 32'h1234);
      drive_idle();
      #1;
      check("rdata_no_op", md_rdata_out, 32'd0);

      run_op(MD_MULTU, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 2, 0, "pre_reset");
      exe_valid_in = 1'b1;
      exe_op_in    = 8'(1 << MD_DIVU);
      exe_src1_in  = 32'd99;
      exe_src2_in  = 32'd4;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hi", hi_out, 32'd0);
      check("arst_lo", lo_out, 32'd0);
      check("arst_busy", {31'd0, md_busy_out}, 32'd0);
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         opb = int'($urandom_range(3, 0));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(7, 0))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(15, 1));
            default: ;
         endcase
         r = model(opb, a, b);
         run_op(opb, a, b, r[63:32], r[31:0], (opb <= MD_MULTU) ? 2 : DIV_ITERS + 1,
                int'($urandom_range(2, 0)), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Controller for the HI/LO multiply/divide resource in the EXE stage of the 5-stage MIPS pipeline. It takes the one-hot `mult_div_op` decoded in ID and carried into EXE, then sequences a 1-cycle multiply or a 32-iteration radix-2 divide. It owns the HI/LO architectural registers and holds EXE's ready low until the result is committed. It also serves MFHI/MFLO reads and MTHI/MTLO writes, and aborts cleanly on an exception flush.

## Interface
Parameters:
- `DIV_ITERS`, 32: divider iterations. Fixed; it is a parameter for the bench only.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `exe_valid_in`  in  1  EXE holds a valid instruction
- `exe_op_in`  in  8  one-hot op: [0] MULT, [1] MULTU, [2] DIV, [3] DIVU, [4] MFHI, [5] MFLO, [6] MTHI, [7] MTLO; all-zero means none
- `exe_src1_in`  in  32  rs value (dividend, multiplicand, MT source)
- `exe_src2_in`  in  32  rt value
- `exe_go_in`  in  1  EXE instruction leaves EXE this cycle (EXE ready && MEM allowin)
- `exe_cancel_in`  in  1  flush of the EXE instruction (exception/eret)
- `md_ready_out`  out  1  muldiv side of EXE ready
- `md_busy_out`  out  1  state != IDLE
- `md_rdata_out`  out  32  HI (MFHI) or LO (MFLO), otherwise 0
- `hi_out`  out  32  HI register
- `lo_out`  out  32  LO register

## Operation
- States: IDLE, MUL, DIV, DONE. Encoding is 2-bit binary.
- Inputs hold stable while `md_ready_out`=0, under the pipeline valid/allowin protocol.
- Start condition: IDLE && exe_valid_in && op[3:0]!=0 && !exe_cancel_in.
  - Latch src1, src2 and the op.
  - MULT/MULTU go to MUL; DIV/DIVU go to DIV.
- MUL state:
  - Compute the 64-bit product, signed for MULT and unsigned for MULTU.
  - HI takes [63:32] and LO takes [31:0]. Move to DONE.
- DIV state:
  - Take absolute values for DIV, raw values for DIVU.
  - The restoring divider runs one quotient bit per cycle. Counter counts 0..DIV_ITERS-1; at DIV_ITERS-1, write HI/LO and move to DONE.
  - Signed fixup: quotient is negated if src1[31]^src2[31]; remainder takes the sign of src1.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor == 0 (signed or unsigned) gives LO=0xFFFFFFFF, HI=src1. This still takes the full DIV_ITERS cycles.
- DONE state:
  - md_ready_out=1.
  - exe_go_in or exe_cancel_in moves to IDLE.
  - Otherwise stay in DONE; never restart the same op.
- Ready: md_ready_out = !exe_valid_in || DONE || (IDLE && op[3:0]==0).
- MFHI/MFLO: combinational read of the current register. It is hazard-free because a MULT/DIV cannot leave EXE before committing.
- MTHI/MTLO: write src1 on the edge where exe_valid_in && exe_go_in && !exe_cancel_in.
- Cancel:
  - exe_cancel_in in any state goes to IDLE next edge, with no HI/LO write and the counter cleared.
  - Cancel wins over the final DIV iteration and the MUL commit in the same cycle.

## Timing
- Reset values: state IDLE, counter 0, hi_out=0, lo_out=0, md_busy_out=0. md_rdata_out is 0 unless an MF op is present.
- Latency is counted from the start edge (T0):
  - MUL: commit at T1, md_ready_out high during T1..; EXE stalls 2 cycles including the issue cycle.
  - DIV: commit at T32, ready high from T32; EXE stalls 33 cycles.
- Back-to-back MULT: DONE→IDLE on the go edge, and the next op starts on the following edge.
- HI/LO are updated exactly once per uncancelled op, at the DONE-entry edge.
- Asynchronous reset mid-divide returns to reset values immediately.

## Structure
- Shared package `md_pkg`:
  - op bit indices (MD_MULT..MD_MTLO)
  - state encoding
  - DIV_ITERS default
- Sub-module `div_iter`:
  - unsigned 32/32 restoring divider
  - ports: clk, rst_n, start, clear, dividend, divisor → quotient, remainder, last
  - signed fixup and divide-by-zero override stay in muldiv_ctrl.
- Target size: ~250 lines including div_iter.

## Test plan
- MULT 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; ready low for exactly 2 cycles.
- DIVU 100/7 → LO=14, HI=2 at T32; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5 after 32 cycles.
- Cancel in DIV cycle 10, and separately in the cycle before commit → HI/LO unchanged, IDLE next cycle, busy=0.
- MTHI 0x1234 then MFHI → rdata=0x1234. A DONE held with exe_go_in=0 for 3 cycles → a single write and no restart.
- Assert rst_n low mid-DIV asynchronously → hi_out=lo_out=0 and busy=0 before the next clock edge.
